led_sched: RTL and testbench



---
 rtl/led_sched.sv | 206 ++++++++++++++++++++
 tb/tb_led_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_sched.sv
// Round-robin time-sharing of the 3 status LEDs between NREQ requesters, with a heartbeat when idle.
// Optional build macro LED_SCHED_PREEMPT_EN gives requester 0 absolute priority.
module led_sched #(
    parameter int unsigned CDIV       = 50_000_000,
    parameter int unsigned SLOT_TICKS = 4,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned NREQ       = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   pat,
    input  logic [NREQ-1:0]     blink,
    output logic [NREQ-1:0]     gnt,
    output logic [2:0]          led,
    output logic                busy
);

    localparam int unsigned PW = $clog2(CDIV);
    localparam int unsigned SW = $clog2(SLOT_TICKS + 1);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_SHOW,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              phase_q, phase_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [2:0]        spat_q, spat_d;
    logic              sblink_q, sblink_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [2:0]        led_q, led_d;
    logic              busy_q;

    logic              tick;
    logic              any_req;
    logic [IW-1:0]     rr_win;
    logic              rr_hit;
    logic [IW-1:0]     win;
    logic              upd_rr;

    assign tick    = (presc_q == PW'(CDIV - 1));
    assign any_req = |req;

    // Round-robin search starting one past the last winner.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        rr_win = rr_q;
        rr_hit = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(rr_q) + k) % NREQ;
            if (!rr_hit && req[IW'(idx)]) begin
                rr_hit = 1'b1;
                rr_win = IW'(idx);
            end
        end
    end

`ifdef LED_SCHED_PREEMPT_EN
    // Requester 0 wins outright and leaves the rotation pointer untouched.
    always_comb begin
        win    = rr_win;
        upd_rr = 1'b1;
        if (req[0]) begin
            win    = '0;
            upd_rr = 1'b0;
        end
    end
`else
    always_comb begin
        win    = rr_win;
        upd_rr = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            phase_q  <= 1'b1;
            slot_q   <= '0;
            gap_q    <= '0;
            rr_q     <= IW'(NREQ - 1);
            owner_q  <= '0;
            spat_q   <= '0;
            sblink_q <= 1'b0;
            gnt_q    <= '0;
            led_q    <= 3'b111;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            gap_q    <= gap_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            spat_q   <= spat_d;
            sblink_q <= sblink_d;
            gnt_q    <= gnt_d;
            led_q    <= led_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // Next-state and registered-output logic; LED/grant values are computed for the coming state.
    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        phase_d  = tick ? ~phase_q : phase_q;
        slot_d   = slot_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        spat_d   = spat_q;
        sblink_d = sblink_q;
        gnt_d    = gnt_q;
        led_d    = led_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                led_d = {3{phase_d}};
                if (any_req) begin
                    state_d = S_ARB;
                end
            end

            S_ARB: begin
                if (any_req) begin
                    owner_d  = win;
                    if (upd_rr) begin
                        rr_d = win;
                    end
                    gnt_d    = NREQ'(1) << win;
                    spat_d   = pat[32'(win) * 3 +: 3];
                    sblink_d = blink[win];
                    led_d    = pat[32'(win) * 3 +: 3];
                    presc_d  = '0;
                    phase_d  = 1'b1;
                    slot_d   = SW'(SLOT_TICKS);
                    state_d  = S_SHOW;
                end else begin
                    gnt_d   = '0;
                    led_d   = {3{phase_d}};
                    state_d = S_IDLE;
                end
            end

            S_SHOW: begin
                if (tick) begin
                    slot_d = slot_q - SW'(1);
                end
                led_d = (sblink_q && !phase_d) ? 3'b000 : spat_q;
`ifdef LED_SCHED_PREEMPT_EN
                if (owner_q != '0 && req[0]) begin
                    state_d = S_ARB;
                end else
`endif
                if (!req[owner_q] || (tick && slot_q == SW'(1))) begin
                    state_d = S_GAP;
                    gnt_d   = '0;
                    led_d   = 3'b000;
                    presc_d = '0;
                    gap_d   = GW'(GAP_TICKS);
                end
            end

            S_GAP: begin
                gnt_d = '0;
                led_d = 3'b000;
                if (tick) begin
                    if (gap_q == GW'(1)) begin
                        if (any_req) begin
                            state_d = S_ARB;
                        end else begin
                            state_d = S_IDLE;
                            led_d   = {3{phase_d}};
                        end
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_sched.sv
// Directed bench for led_sched with CDIV=4, SLOT_TICKS=3, GAP_TICKS=1, NREQ=4.
module tb_led_sched;

    localparam int unsigned CDIV       = 4;
    localparam int unsigned SLOT_TICKS = 3;
    localparam int unsigned GAP_TICKS  = 1;
    localparam int unsigned NREQ       = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  req;
    logic [11:0] pat;
    logic [3:0]  blink;
    logic [3:0]  gnt;
    logic [2:0]  led;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_gnt [4];
    logic [2:0] exp_led [4];

    always #5 clk = ~clk;

    led_sched #(
        .CDIV       (CDIV),
        .SLOT_TICKS (SLOT_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .NREQ       (NREQ)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .req   (req),
        .pat   (pat),
        .blink (blink),
        .gnt   (gnt),
        .led   (led),
        .busy  (busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cg(input string tag, input logic [3:0] e);
        chk({tag, ".gnt"}, {28'd0, gnt}, {28'd0, e});
    endtask

    task automatic cl(input string tag, input logic [2:0] e);
        chk({tag, ".led"}, {29'd0, led}, {29'd0, e});
    endtask

    task automatic cb(input string tag, input logic e);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e});
    endtask

    // Asserted and released between clock edges; outputs must reset without waiting for a clock.
    task automatic rst_pulse(input string tag);
        n_rst = 1'b0;
        #1;
        cl(tag, 3'b111);
        cg(tag, 4'b0000);
        cb(tag, 1'b0);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b1;
        req   = 4'b0000;
        blink = 4'b0000;
        pat   = {3'b110, 3'b101, 3'b011, 3'b001};
`ifdef LED_SCHED_PREEMPT_EN
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_led = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_led = '{3'b001, 3'b011, 3'b110, 3'b001};
`endif
        repeat (2) @(posedge clk);
        #2;

        // Reset and heartbeat
        rst_pulse("por");
        cyc(3); cl("hb_on", 3'b111); cb("hb_idle", 1'b0);
        cyc(1); cl("hb_off", 3'b000);
        cyc(3); cl("hb_off_hold", 3'b000);
        cyc(1); cl("hb_on2", 3'b111);

        // Single solid request, gap, re-grant
        req = 4'b0100;
        cyc(1); cg("single_arb", 4'b0000); cb("single_arb", 1'b1);
        cyc(1); cg("single_gnt", 4'b0100); cl("single_gnt", 3'b101);
        cyc(11); cg("single_end", 4'b0100); cl("single_end", 3'b101);
        cyc(1); cg("single_gap", 4'b0000); cl("single_gap", 3'b000);
        cyc(3); cl("single_gap_end", 3'b000);
        cyc(1); cg("single_rearb", 4'b0000);
        cyc(1); cg("single_regnt", 4'b0100); cl("single_regnt", 3'b101);

        // Mid-slot reset, then rotation with req=1011
        req = 4'b1011;
        rst_pulse("midslot");
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            cg($sformatf("rot%0d_gnt", i), exp_gnt[i]);
            cl($sformatf("rot%0d_gnt", i), exp_led[i]);
            cyc(11); cg($sformatf("rot%0d_hold", i), exp_gnt[i]);
            cyc(1);  cg($sformatf("rot%0d_gap", i), 4'b0000); cl($sformatf("rot%0d_gap", i), 3'b000);
            cyc(4);  cg($sformatf("rot%0d_arb", i), 4'b0000);
            cyc(1);
        end

        // Blinking pattern; pattern change while granted is ignored
        req   = 4'b0010;
        blink = 4'b0010;
        rst_pulse("blink");
        cyc(2); cg("blink_gnt", 4'b0010); cl("blink_on0", 3'b011);
        pat[5:3] = 3'b111;
        cyc(3); cl("blink_on0_end", 3'b011);
        cyc(1); cl("blink_off", 3'b000);
        cyc(3); cl("blink_off_end", 3'b000);
        cyc(1); cl("blink_on1", 3'b011);
        cyc(3); cl("blink_on1_end", 3'b011);
        cyc(1); cl("blink_gap", 3'b000); cg("blink_gap", 4'b0000);
        pat[5:3] = 3'b011;

        // Early release by requester 3
        req   = 4'b1000;
        blink = 4'b0000;
        rst_pulse("early");
        cyc(2); cg("early_gnt", 4'b1000); cl("early_gnt", 3'b110);
        cyc(4); cg("early_hold", 4'b1000);
        req = 4'b0000;
        cyc(1); cg("early_gap", 4'b0000); cl("early_gap", 3'b000); cb("early_gap", 1'b1);
        cyc(3); cl("early_gap_end", 3'b000); cb("early_gap_end", 1'b1);
        cyc(1); cl("early_idle", 3'b111); cb("early_idle", 1'b0); cg("early_idle", 4'b0000);
        cyc(4); cl("early_hb", 3'b000);

        // Requester 0 arriving while requester 2 holds the slot
        req = 4'b0100;
        rst_pulse("pre");
        cyc(2); cg("pre_own2", 4'b0100);
        cyc(2);
        req = 4'b0101;
        cyc(1); cg("pre_edge1", 4'b0100);
`ifdef LED_SCHED_PREEMPT_EN
        cyc(1); cg("pre_gnt0", 4'b0001); cl("pre_gnt0", 3'b001);
`else
        cyc(8); cg("pre_slot_end", 4'b0100);
        cyc(1); cg("pre_gap", 4'b0000); cl("pre_gap", 3'b000);
        cyc(4); cg("pre_arb", 4'b0000);
        cyc(1); cg("pre_gnt0", 4'b0001); cl("pre_gnt0", 3'b001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
